trapez_input_stage: RTL

Front end of the trapezoidal shaping chain and the producer of the shaper's sample tap bus. It registers raw ADC samples and subtracts a tracked baseline. It drives a signed delay line that the shaper reads through fixed tap indices. It also generates the `pulse_time` gate with a trigger/holdoff state machine, which the shaper uses to release its accumulators.

---
 rtl/trapez_input_stage_if.sv | 11 +
 rtl/trapez_input_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/trapez_input_stage_if.sv
// ADC sample stream into the trapezoidal shaper front end.
// The master side drives one sample per strobe; the input stage is the slave.
interface trapez_input_stage_if #(
    parameter int SIZE_SHAPER_DATA = 16
) ();
    logic [SIZE_SHAPER_DATA-1:0] adc_data;
    logic                        adc_valid;

    modport master (output adc_data, output adc_valid);
    modport slave  (input  adc_data, input  adc_valid);
endinterface

// File: rtl/trapez_input_stage.sv
// Trapezoidal shaper input stage: baseline tracking and subtraction, the
// signed sample delay line read by the shaper taps, and the trigger/holdoff
// state machine that produces the pulse_time gate.
module trapez_input_stage #(
    parameter int SIZE_SHAPER_DATA         = 16,
    parameter int SIZE_SHAPER_ADD_CAPACITY = 8,
    parameter int SIZE_SHAPER_SHIFT_REG    = 64,
    parameter int SIZE_SHAPER_CONSTANT     = 16,
    parameter int BL_LOG2                  = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    trapez_input_stage_if.slave                       adc,
    input  logic [SIZE_SHAPER_CONSTANT-1:0]           threshold,
    input  logic [SIZE_SHAPER_CONSTANT-1:0]           pulse_len,
    input  logic [SIZE_SHAPER_CONSTANT-1:0]           holdoff_len,
    output logic signed [SIZE_SHAPER_DATA+SIZE_SHAPER_ADD_CAPACITY:0]
                                                      shift_reg_output_sig [SIZE_SHAPER_SHIFT_REG-1:0],
    output logic                                      pulse_time,
    output logic                                      pileup,
    output logic [SIZE_SHAPER_DATA-1:0]               baseline,
    output logic                                      busy
);

    localparam int D  = SIZE_SHAPER_DATA;
    localparam int W  = SIZE_SHAPER_DATA + SIZE_SHAPER_ADD_CAPACITY + 1;
    localparam int N  = SIZE_SHAPER_SHIFT_REG;
    localparam int C  = SIZE_SHAPER_CONSTANT;
    localparam int B  = BL_LOG2;
    localparam int AW = D + B;

    localparam logic [C-1:0] CNT_ONE = {{(C-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, GATE, HOLDOFF} state_t;

    // Delay line and baseline state
    logic signed [W-1:0] tap_q [N-1:0];
    logic signed [W-1:0] tap0_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AW:0]         acc_sum;
    logic [D-1:0]        sample_q;
    logic                init_q;
    logic                proc_q;

    // Trigger state
    state_t              state_q;
    logic [C-1:0]        cnt_q;
    logic                above_q;
    logic                pulse_q;
    logic                busy_q;
    logic                pileup_q;

    logic signed [W-1:0] adc_ext;
    logic signed [W-1:0] bl_ext;
    logic signed [W-1:0] thr_ext;
    logic                above_w;
    logic                trig_w;
    logic                cnt_last;
    logic [C-1:0]        plen;

    assign baseline = acc_q[AW-1:B];

    assign adc_ext = $signed({{(W-D){1'b0}}, adc.adc_data});
    assign bl_ext  = $signed({{(W-D){1'b0}}, baseline});
    assign thr_ext = $signed({{(W-C){1'b0}}, threshold});

    // The very first sample seeds the baseline with itself, so its tap is 0.
    assign tap0_d = init_q ? (adc_ext - bl_ext) : '0;

    assign above_w  = (tap_q[0] >= thr_ext);
    assign trig_w   = enable && proc_q && (state_q == IDLE) && above_w;
    assign cnt_last = (cnt_q <= CNT_ONE);
    assign plen     = (pulse_len == '0) ? CNT_ONE : pulse_len;

    // Baseline accumulator next state. The update runs in the cycle after the
    // sample, once the trigger decision is known, so a triggering sample never
    // leaks into the baseline.
    always_comb begin
        acc_sum = {1'b0, acc_q}
                + {{(B+1){1'b0}}, sample_q}
                - {{(B+1){1'b0}}, acc_q[AW-1:B]};
        acc_d = acc_q;
        if (adc.adc_valid && !init_q) begin
            acc_d = {adc.adc_data, {B{1'b0}}};
        end else if (proc_q && init_q && (state_q == IDLE) && !trig_w) begin
            acc_d = acc_sum[AW-1:0];
        end
    end

    // Baseline accumulator, init flag, sample register and processing strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            init_q   <= 1'b0;
            sample_q <= '0;
            proc_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            proc_q <= adc.adc_valid;
            if (adc.adc_valid) begin
                init_q   <= 1'b1;
                sample_q <= adc.adc_data;
            end
        end
    end

    // Baseline-subtracted delay line; shifts only on a sample strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) tap_q[i] <= '0;
        end else if (adc.adc_valid) begin
            tap_q[0] <= tap0_d;
            for (int i = 1; i < N; i++) tap_q[i] <= tap_q[i-1];
        end
    end

    // Trigger / gate / holdoff FSM with registered gate, busy and pileup.
    // It only advances in the cycle after a sample, when tap 0 is fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            above_q  <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            pileup_q <= 1'b0;
        end else begin
            pileup_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
                if (proc_q) above_q <= above_w;
            end else if (proc_q) begin
                above_q <= above_w;
                case (state_q)
                    IDLE: begin
                        if (above_w) begin
                            state_q <= GATE;
                            cnt_q   <= plen;
                            pulse_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    GATE: begin
                        if (above_w && !above_q) begin
                            // fresh rising crossing inside the gate: extend it
                            cnt_q    <= plen;
                            pileup_q <= 1'b1;
                        end else if (cnt_last) begin
                            pulse_q <= 1'b0;
                            if (holdoff_len == '0) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= HOLDOFF;
                                cnt_q   <= holdoff_len;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    HOLDOFF: begin
                        if (cnt_last) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign shift_reg_output_sig = tap_q;
    assign pulse_time           = pulse_q;
    assign busy                 = busy_q;
    assign pileup               = pileup_q;

endmodule
